axis_chk32: RTL and testbench

- AXI-Stream sink and pattern checker: the receive-side counterpart of the team's 32-bit block pattern generator.
- Sits on an MM2S DMA output, or in loopback after S2MM->DDR->MM2S.
- Consumes fixed-length frames and verifies the payload pattern, TKEEP and TLAST position.
- Exposes saturating frame/error counters and first-error capture for software readback.

---
 rtl/axis_chk32.sv | 118 +++++++++++
 tb/tb_axis_chk32.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_chk32.sv
// AXI-Stream sink that checks fixed-length frames of {AA,AA,AA,idx[7:0]} words, TKEEP and TLAST position.
// Status updates on the edge that takes the beat; s_tready is registered from en (optionally LFSR-throttled).
module axis_chk32 #(
  parameter int unsigned BYTES_PER_BLOCK = 16384,
  parameter int unsigned THROTTLE        = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [3:0]  s_tkeep,
  output logic [31:0] frame_cnt,
  output logic [31:0] good_cnt,
  output logic [31:0] data_err_cnt,
  output logic [31:0] len_err_cnt,
  output logic        err_sticky,
  output logic [31:0] first_err_word,
  output logic [31:0] first_err_data
);

  localparam logic [31:0] LAST_IDX = 32'(BYTES_PER_BLOCK / 4 - 1);

  logic [31:0] idx;
  logic        frame_bad;
  logic        ready_r;
  logic        cap_done;
  logic [15:0] lfsr;

  logic        beat;
  logic [31:0] exp_word;
  logic        data_bad;
  logic        eof;
  logic        short_err;
  logic        long_err;
  logic        len_bad;
  logic        frame_good;
  logic        lfsr_fb;

  assign s_tready = ready_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // A beat taken while en is low belongs to a frame being discarded, so it is ignored.
  always_comb begin
    beat       = s_tvalid & ready_r & en;
    exp_word   = {24'hAAAAAA, idx[7:0]};
    data_bad   = beat & ((s_tdata != exp_word) | (s_tkeep != 4'hF));
    eof        = beat & s_tlast;
    short_err  = eof & (idx < LAST_IDX);
    long_err   = beat & ~s_tlast & (idx == LAST_IDX);
    len_bad    = short_err | long_err;
    frame_good = eof & ~data_bad & ~short_err & ~frame_bad;
    lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx            <= '0;
      frame_bad      <= 1'b0;
      ready_r        <= 1'b0;
      cap_done       <= 1'b0;
      lfsr           <= 16'hACE1;
      frame_cnt      <= '0;
      good_cnt       <= '0;
      data_err_cnt   <= '0;
      len_err_cnt    <= '0;
      err_sticky     <= 1'b0;
      first_err_word <= '0;
      first_err_data <= '0;
    end else begin
      if (en) lfsr <= {lfsr[14:0], lfsr_fb};
      ready_r <= (THROTTLE != 0) ? (en & lfsr[0]) : en;

      if (!en) begin
        idx       <= '0;
        frame_bad <= 1'b0;
      end else if (beat) begin
        if (s_tlast) begin
          idx       <= '0;
          frame_bad <= 1'b0;
        end else begin
          idx <= idx + 32'd1;
          if (data_bad | long_err) frame_bad <= 1'b1;
        end
      end

      // clr wins over a beat in the same cycle; only idx/frame_bad above see that beat.
      if (clr) begin
        frame_cnt      <= '0;
        good_cnt       <= '0;
        data_err_cnt   <= '0;
        len_err_cnt    <= '0;
        err_sticky     <= 1'b0;
        cap_done       <= 1'b0;
        first_err_word <= '0;
        first_err_data <= '0;
      end else begin
        frame_cnt    <= sat_inc(frame_cnt, eof);
        good_cnt     <= sat_inc(good_cnt, frame_good);
        data_err_cnt <= sat_inc(data_err_cnt, data_bad);
        len_err_cnt  <= sat_inc(len_err_cnt, len_bad);
        if (data_bad | len_bad) err_sticky <= 1'b1;
        if (data_bad && !cap_done) begin
          cap_done       <= 1'b1;
          first_err_word <= idx;
          first_err_data <= s_tdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_chk32.sv
// Bench for axis_chk32: W=1 vector table, W=4096 directed frames, W=256 throttled random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_axis_chk32;

  localparam int W0 = 4096;
  localparam int W1 = 256;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        en [3];
  logic        clr [3];
  logic        s_tvalid [3];
  logic        s_tlast [3];
  logic [31:0] s_tdata [3];
  logic [3:0]  s_tkeep [3];
  logic        s_tready [3];
  logic        err_sticky [3];
  logic [31:0] frame_cnt [3];
  logic [31:0] good_cnt [3];
  logic [31:0] data_err_cnt [3];
  logic [31:0] len_err_cnt [3];
  logic [31:0] first_err_word [3];
  logic [31:0] first_err_data [3];

  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;

  always #5 aclk = ~aclk;

  axis_chk32 #(.BYTES_PER_BLOCK(W0 * 4), .THROTTLE(0)) u_w4096 (
    .aclk(aclk), .aresetn(aresetn), .en(en[0]), .clr(clr[0]),
    .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]),
    .s_tlast(s_tlast[0]), .s_tkeep(s_tkeep[0]),
    .frame_cnt(frame_cnt[0]), .good_cnt(good_cnt[0]), .data_err_cnt(data_err_cnt[0]),
    .len_err_cnt(len_err_cnt[0]), .err_sticky(err_sticky[0]),
    .first_err_word(first_err_word[0]), .first_err_data(first_err_data[0]));

  axis_chk32 #(.BYTES_PER_BLOCK(W1 * 4), .THROTTLE(1)) u_w256_thr (
    .aclk(aclk), .aresetn(aresetn), .en(en[1]), .clr(clr[1]),
    .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]),
    .s_tlast(s_tlast[1]), .s_tkeep(s_tkeep[1]),
    .frame_cnt(frame_cnt[1]), .good_cnt(good_cnt[1]), .data_err_cnt(data_err_cnt[1]),
    .len_err_cnt(len_err_cnt[1]), .err_sticky(err_sticky[1]),
    .first_err_word(first_err_word[1]), .first_err_data(first_err_data[1]));

  axis_chk32 #(.BYTES_PER_BLOCK(4), .THROTTLE(0)) u_w1 (
    .aclk(aclk), .aresetn(aresetn), .en(en[2]), .clr(clr[2]),
    .s_tdata(s_tdata[2]), .s_tvalid(s_tvalid[2]), .s_tready(s_tready[2]),
    .s_tlast(s_tlast[2]), .s_tkeep(s_tkeep[2]),
    .frame_cnt(frame_cnt[2]), .good_cnt(good_cnt[2]), .data_err_cnt(data_err_cnt[2]),
    .len_err_cnt(len_err_cnt[2]), .err_sticky(err_sticky[2]),
    .first_err_word(first_err_word[2]), .first_err_data(first_err_data[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input int k, input string tag, input int f, input int g,
                           input int de, input int le, input logic st);
    check($sformatf("%s.frame_cnt", tag), frame_cnt[k], f);
    check($sformatf("%s.good_cnt", tag), good_cnt[k], g);
    check($sformatf("%s.data_err_cnt", tag), data_err_cnt[k], de);
    check($sformatf("%s.len_err_cnt", tag), len_err_cnt[k], le);
    check($sformatf("%s.err_sticky", tag), {31'd0, err_sticky[k]}, {31'd0, st});
  endtask

  // One beat: holds tvalid until the DUT takes it (bounded), returns #1 after the taking edge.
  task automatic send(input int k, input logic [31:0] d, input logic [3:0] kp,
                      input logic lst, input bit gaps);
    logic got;
    if (gaps) begin
      s_tvalid[k] = 1'b0;
      while ($urandom_range(3) == 0) begin @(posedge aclk); #1; end
    end
    s_tvalid[k] = 1'b1; s_tdata[k] = d; s_tkeep[k] = kp; s_tlast[k] = lst;
    for (int n = 0; ; n++) begin
      got = s_tready[k];
      if (!got) stalls++;
      @(posedge aclk); #1;
      if (got) break;
      if (n == 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout dut%0d: s_tready stayed 0 for %0d cycles, want 1", k, n);
        break;
      end
    end
    s_tvalid[k] = 1'b0;
  endtask

  // Pattern words start..stop-1, optional single corrupted word, tlast on the final one if last.
  task automatic frame(input int k, input int start, input int stop, input int bad_i,
                       input logic [31:0] bad_v, input bit last, input bit gaps);
    for (int i = start; i < stop; i++) begin
      logic [31:0] w;
      w = {24'hAAAAAA, i[7:0]};
      if (i == bad_i) w = bad_v;
      send(k, w, 4'hF, last && (i == stop - 1), gaps);
    end
  endtask

  task automatic pulse_clr(input int k);
    clr[k] = 1'b1;
    @(posedge aclk); #1;
    clr[k] = 1'b0;
  endtask

  // Frame-level reference model for the throttled W=256 instance.
  typedef struct { logic [31:0] d; logic [3:0] kp; } beat_t;
  int m_frame = 0, m_good = 0, m_derr = 0, m_len = 0;
  bit m_sticky = 0, m_cap = 0;
  logic [31:0] m_few = '0, m_fed = '0;

  task automatic rand_frame(input int kind, input int r);
    beat_t fq[$];
    int len, nerr, errs;
    len = (kind == 2) ? $urandom_range(W1 - 1, 1) : (kind == 3) ? W1 + $urandom_range(20, 1) : W1;
    for (int i = 0; i < len; i++) fq.push_back('{{24'hAAAAAA, i[7:0]}, 4'hF});
    nerr = (kind == 4) ? $urandom_range(3, 1) : (kind >= 2) ? $urandom_range(1) : 0;
    for (int e = 0; e < nerr; e++) begin
      int p;
      p = $urandom_range(len - 1);
      if ($urandom_range(1) == 0) fq[p].d = fq[p].d ^ (32'h1 << $urandom_range(31));
      else fq[p].kp = 4'($urandom_range(14));
    end
    errs = 0;
    for (int i = 0; i < len; i++) begin
      logic [31:0] ew;
      ew = {24'hAAAAAA, i[7:0]};
      if (fq[i].d != ew || fq[i].kp != 4'hF) begin
        errs++;
        if (!m_cap) begin m_cap = 1; m_few = i; m_fed = fq[i].d; end
      end
      send(1, fq[i].d, fq[i].kp, i == len - 1, 1'b1);
    end
    m_frame++;
    m_derr += errs;
    if (len != W1) m_len++;
    if (errs == 0 && len == W1) m_good++;
    if (errs != 0 || len != W1) m_sticky = 1;
    check_cnt(1, $sformatf("rand%0d", r), m_frame, m_good, m_derr, m_len, m_sticky);
    check($sformatf("rand%0d.first_err_word", r), first_err_word[1], m_few);
    check($sformatf("rand%0d.first_err_data", r), first_err_data[1], m_fed);
  endtask

  typedef struct {
    logic [31:0] d; logic [3:0] kp; logic lst;
    int f, g, de, le; logic st; logic [31:0] fed;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b1; clr[k] = 1'b0; s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0;
      s_tdata[k] = '0; s_tkeep[k] = '0;
    end
    repeat (3) @(posedge aclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d.s_tready", k), {31'd0, s_tready[k]}, 32'd0);
      check_cnt(k, $sformatf("reset%0d", k), 0, 0, 0, 0, 1'b0);
      check($sformatf("reset%0d.first_err_word", k), first_err_word[k], 32'd0);
      check($sformatf("reset%0d.first_err_data", k), first_err_data[k], 32'd0);
    end
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // W=1: every beat is a whole frame; a beat without tlast makes a long frame.
    tbl[0] = '{32'hAAAAAA00, 4'hF, 1'b1, 1, 1, 0, 0, 1'b0, 32'h0};
    tbl[1] = '{32'hAAAAAA00, 4'hF, 1'b1, 2, 2, 0, 0, 1'b0, 32'h0};
    tbl[2] = '{32'hAAAAAA01, 4'hF, 1'b1, 3, 2, 1, 0, 1'b1, 32'hAAAAAA01};
    tbl[3] = '{32'hAAAAAA00, 4'h7, 1'b1, 4, 2, 2, 0, 1'b1, 32'hAAAAAA01};
    tbl[4] = '{32'hAAAAAA00, 4'hF, 1'b0, 4, 2, 2, 1, 1'b1, 32'hAAAAAA01};
    tbl[5] = '{32'hAAAAAA01, 4'hF, 1'b1, 5, 2, 2, 1, 1'b1, 32'hAAAAAA01};
    tbl[6] = '{32'hAAAAAA00, 4'hF, 1'b1, 6, 3, 2, 1, 1'b1, 32'hAAAAAA01};
    for (int v = 0; v < 7; v++) begin
      send(2, tbl[v].d, tbl[v].kp, tbl[v].lst, 1'b0);
      check_cnt(2, $sformatf("w1_vec%0d", v), tbl[v].f, tbl[v].g, tbl[v].de, tbl[v].le, tbl[v].st);
      check($sformatf("w1_vec%0d.first_err_word", v), first_err_word[2], 32'd0);
      check($sformatf("w1_vec%0d.first_err_data", v), first_err_data[2], tbl[v].fed);
    end

    // W=4096 directed frames.
    stalls = 0;
    frame(0, 0, W0, -1, '0, 1'b1, 1'b0);
    frame(0, 0, W0, -1, '0, 1'b1, 1'b0);
    check_cnt(0, "clean2", 2, 2, 0, 0, 1'b0);
    check("clean2.ready_stalls", stalls, 0);

    pulse_clr(0);
    check_cnt(0, "clr_a", 0, 0, 0, 0, 1'b0);
    frame(0, 0, W0, 100, 32'hAAAAAA55, 1'b1, 1'b0);
    check_cnt(0, "word100", 1, 0, 1, 0, 1'b1);
    check("word100.first_err_word", first_err_word[0], 32'd100);
    check("word100.first_err_data", first_err_data[0], 32'hAAAAAA55);

    pulse_clr(0);
    frame(0, 0, 11, -1, '0, 1'b1, 1'b0);
    check_cnt(0, "short", 1, 0, 0, 1, 1'b1);
    frame(0, 0, W0, -1, '0, 1'b1, 1'b0);
    check_cnt(0, "short_then_clean", 2, 1, 0, 1, 1'b1);

    pulse_clr(0);
    frame(0, 0, W0 + 4, -1, '0, 1'b1, 1'b0);
    check_cnt(0, "long", 1, 0, 0, 1, 1'b1);

    pulse_clr(0);
    frame(0, 0, 2000, -1, '0, 1'b0, 1'b0);
    en[0] = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("abort.s_tready", {31'd0, s_tready[0]}, 32'd0);
    check_cnt(0, "abort_idle", 0, 0, 0, 0, 1'b0);
    en[0] = 1'b1;
    @(posedge aclk); #1;
    frame(0, 0, W0, -1, '0, 1'b1, 1'b0);
    check_cnt(0, "abort_then_clean", 1, 1, 0, 0, 1'b0);

    frame(0, 0, 5, -1, '0, 1'b0, 1'b0);
    clr[0] = 1'b1;
    send(0, 32'hDEAD0005, 4'hF, 1'b0, 1'b0);
    clr[0] = 1'b0;
    check_cnt(0, "clr_with_err", 0, 0, 0, 0, 1'b0);
    check("clr_with_err.first_err_word", first_err_word[0], 32'd0);
    check("clr_with_err.first_err_data", first_err_data[0], 32'd0);
    frame(0, 6, W0, -1, '0, 1'b1, 1'b0);
    check_cnt(0, "clr_frame_bad_kept", 1, 0, 0, 0, 1'b0);

    // Throttled W=256 instance: three clean frames, then random frames vs the model.
    stalls = 0;
    for (int r = 0; r < 3; r++) rand_frame(0, r);
    check("thr.good_cnt", good_cnt[1], 32'd3);
    check("thr.ready_toggled", {31'd0, stalls != 0}, 32'd1);
    for (int r = 3; r < 25; r++) rand_frame($urandom_range(4), r);

    // Reset in the middle of a frame.
    frame(1, 0, 50, -1, '0, 1'b0, 1'b1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("midrst.s_tready", {31'd0, s_tready[1]}, 32'd0);
    check_cnt(1, "midrst", 0, 0, 0, 0, 1'b0);
    aresetn = 1'b1;
    frame(1, 0, W1, -1, '0, 1'b1, 1'b1);
    check_cnt(1, "midrst_then_clean", 1, 1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
